// File: rtl/oct_tone_gen.sv
// -----------------------------------------------------------------------------
// oct_tone_gen
//
// Square-wave tone generator driven by the octave FSM. The per-note base
// half-period (octave O1) is divided by 2^octave to give the effective
// half-period. The tone is 50% duty: high for eff cycles, then low for eff
// cycles. Note and octave changes are sampled only at half-period boundaries,
// so the output never produces a runt pulse. Releasing the key stops the
// tone on the next clock edge.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   note_en    1 = key held, tone requested
//   note_div   base half-period for O1, in clk cycles (DIV_W bits)
//   octave     octave state 0..6 (O1..O7); 7 is invalid and stops the tone
//   tone_out   registered square-wave tone
//   rise_tick  registered one-cycle pulse on each rising edge of tone_out
//   active     registered, 1 while the generator is running
// -----------------------------------------------------------------------------
module oct_tone_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             note_en,
    input  logic [DIV_W-1:0] note_div,
    input  logic [2:0]       octave,
    output logic             tone_out,
    output logic             rise_tick,
    output logic             active
);

    localparam int unsigned OCT_W   = 3;
    localparam logic [OCT_W-1:0] OCT_INVALID = OCT_W'(7);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Registered state
    state_e           state_q;
    state_e           state_d;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             tone_q;
    logic             tone_d;
    logic             rise_q;
    logic             rise_d;
    logic             active_q;
    logic             active_d;

    // Combinational helpers
    logic [DIV_W-1:0] eff_c;
    logic             start_ok_c;
    logic             cnt_zero_c;

    // Effective half-period from the inputs presented this cycle; a shift
    // that empties the value yields 0 and blocks the tone.
    always_comb begin
        eff_c      = DIV_W'(note_div >> octave);
        start_ok_c = note_en && (octave != OCT_INVALID) && (eff_c != '0);
        cnt_zero_c = (cnt_q == '0);
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tone_d   = tone_q;
        rise_d   = 1'b0;
        active_d = active_q;

        unique case (state_q)
            ST_IDLE: begin
                tone_d   = 1'b0;
                active_d = 1'b0;
                cnt_d    = '0;
                if (start_ok_c) begin
                    // Every tone begins with a full high half-period.
                    state_d  = ST_RUN;
                    tone_d   = 1'b1;
                    rise_d   = 1'b1;
                    active_d = 1'b1;
                    cnt_d    = eff_c - DIV_W'(1);
                end
            end

            ST_RUN: begin
                if (!note_en) begin
                    // Key release stops the tone immediately.
                    state_d  = ST_IDLE;
                    tone_d   = 1'b0;
                    active_d = 1'b0;
                    cnt_d    = '0;
                end else if (!cnt_zero_c) begin
                    cnt_d = cnt_q - DIV_W'(1);
                end else if (!start_ok_c) begin
                    // Boundary with an unusable note/octave: stop cleanly.
                    state_d  = ST_IDLE;
                    tone_d   = 1'b0;
                    active_d = 1'b0;
                    cnt_d    = '0;
                end else begin
                    // Boundary: new note/octave take effect from here.
                    tone_d = ~tone_q;
                    rise_d = ~tone_q;
                    cnt_d  = eff_c - DIV_W'(1);
                end
            end

            default: begin
                state_d  = ST_IDLE;
                tone_d   = 1'b0;
                active_d = 1'b0;
                cnt_d    = '0;
            end
        endcase
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            tone_q   <= 1'b0;
            rise_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tone_q   <= tone_d;
            rise_q   <= rise_d;
            active_q <= active_d;
        end
    end

    assign tone_out  = tone_q;
    assign rise_tick = rise_q;
    assign active    = active_q;

endmodule

// File: tb/tb_oct_tone_gen.sv
// -----------------------------------------------------------------------------
// tb_oct_tone_gen
//
// Table of input segments run through a cycle-level reference model; expected
// outputs are queued at drive time and compared one cycle later. A few
// hand-written sequences measure pulse widths around octave changes and
// key release/restart.
// -----------------------------------------------------------------------------
module tb_oct_tone_gen;

    localparam int unsigned DIV_W = 16;

    logic             clk;
    logic             rst;
    logic             note_en;
    logic [DIV_W-1:0] note_div;
    logic [2:0]       octave;
    logic             tone_out;
    logic             rise_tick;
    logic             active;

    oct_tone_gen #(.DIV_W(DIV_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .note_en   (note_en),
        .note_div  (note_div),
        .octave    (octave),
        .tone_out  (tone_out),
        .rise_tick (rise_tick),
        .active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             r;
        logic             en;
        logic [DIV_W-1:0] div;
        logic [2:0]       oct;
        int               cycles;
        int               exp_rises;
        logic             exp_active;
    } seg_t;

    int checks;
    int errors;
    int cyc;

    // Reference model state: rem counts cycles left in the current half-period.
    logic m_run;
    logic m_level;
    logic m_rise;
    int   m_rem;

    logic [2:0] exp_q[$];
    int         rise_cnt;

    function automatic int model_eff(input logic [DIV_W-1:0] d, input logic [2:0] o);
        if (o == 3'd7) return 0;
        return int'(d) / (1 << o);
    endfunction

    task automatic model_step(input logic r, input logic e,
                              input logic [DIV_W-1:0] d, input logic [2:0] o);
        int  eff;
        logic ok;
        eff = model_eff(d, o);
        ok  = e && (eff > 0);
        if (r) begin
            m_run = 0; m_level = 0; m_rise = 0; m_rem = 0;
        end else if (!m_run) begin
            if (ok) begin
                m_run = 1; m_level = 1; m_rise = 1; m_rem = eff;
            end else begin
                m_level = 0; m_rise = 0;
            end
        end else if (!e) begin
            m_run = 0; m_level = 0; m_rise = 0; m_rem = 0;
        end else begin
            m_rem = m_rem - 1;
            if (m_rem > 0) begin
                m_rise = 0;
            end else if (ok) begin
                m_level = !m_level;
                m_rise  = m_level;
                m_rem   = eff;
            end else begin
                m_run = 0; m_level = 0; m_rise = 0; m_rem = 0;
            end
        end
    endtask

    // Drive one cycle, queue the model's expectation, compare after the edge.
    task automatic step(input logic r, input logic e,
                        input logic [DIV_W-1:0] d, input logic [2:0] o);
        logic [2:0] exp_v;
        logic [2:0] got_v;
        rst = r; note_en = e; note_div = d; octave = o;
        model_step(r, e, d, o);
        exp_q.push_back({m_level, m_rise, m_run});
        @(posedge clk);
        #1;
        cyc++;
        got_v = {tone_out, rise_tick, active};
        exp_v = exp_q.pop_front();
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL cycle %0d outputs {tone,rise,active}: got %b expected %b",
                     cyc, got_v, exp_v);
        end
        if (rise_tick === 1'b1) rise_cnt++;
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Count consecutive cycles with tone_out == lvl, holding inputs (bounded).
    task automatic run_len(input logic lvl, input logic [DIV_W-1:0] d,
                           input logic [2:0] o, output int n);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            step(1'b0, 1'b1, d, o);
            if (tone_out !== lvl) break;
            n++;
        end
    endtask

    seg_t segs[16];

    initial begin
        int n;
        checks = 0; errors = 0; cyc = 0; rise_cnt = 0;
        m_run = 0; m_level = 0; m_rise = 0; m_rem = 0;
        rst = 1'b1; note_en = 1'b0; note_div = '0; octave = '0;

        segs[0]  = '{1'b1, 1'b1, 16'd8,     3'd0, 2,  0, 1'b0};
        segs[1]  = '{1'b0, 1'b1, 16'd8,     3'd0, 33, 3, 1'b1};
        segs[2]  = '{1'b0, 1'b1, 16'd8,     3'd2, 20, 3, 1'b1};
        segs[3]  = '{1'b0, 1'b1, 16'd8,     3'd3, 6,  3, 1'b1};
        segs[4]  = '{1'b0, 1'b1, 16'd8,     3'd4, 3,  0, 1'b0};
        segs[5]  = '{1'b0, 1'b1, 16'd100,   3'd7, 5,  0, 1'b0};
        segs[6]  = '{1'b0, 1'b1, 16'd100,   3'd1, 10, 1, 1'b1};
        segs[7]  = '{1'b0, 1'b1, 16'd100,   3'd7, 45, 0, 1'b0};
        segs[8]  = '{1'b0, 1'b1, 16'd10,    3'd0, 4,  1, 1'b1};
        segs[9]  = '{1'b0, 1'b0, 16'd10,    3'd0, 1,  0, 1'b0};
        segs[10] = '{1'b0, 1'b1, 16'd10,    3'd0, 21, 2, 1'b1};
        segs[11] = '{1'b1, 1'b1, 16'd10,    3'd0, 1,  0, 1'b0};
        segs[12] = '{1'b0, 1'b1, 16'd8,     3'd0, 17, 2, 1'b1};
        segs[13] = '{1'b0, 1'b1, 16'd0,     3'd0, 10, 0, 1'b0};
        segs[14] = '{1'b0, 1'b1, 16'd64,    3'd6, 4,  2, 1'b1};
        segs[15] = '{1'b0, 1'b1, 16'd63,    3'd6, 2,  0, 1'b0};

        #1;
        for (int s = 0; s < 16; s++) begin
            rise_cnt = 0;
            for (int c = 0; c < segs[s].cycles; c++)
                step(segs[s].r, segs[s].en, segs[s].div, segs[s].oct);
            check_int($sformatf("seg%0d rise count", s), rise_cnt, segs[s].exp_rises);
            check_int($sformatf("seg%0d final active", s), int'(active), int'(segs[s].exp_active));
        end

        // Octave 0 -> 2 mid high phase: old half completes, then period 4.
        step(1'b1, 1'b1, 16'd8, 3'd0);
        step(1'b0, 1'b1, 16'd8, 3'd0);
        step(1'b0, 1'b1, 16'd8, 3'd0);
        step(1'b0, 1'b1, 16'd8, 3'd0);
        run_len(1'b1, 16'd8, 3'd2, n);
        check_int("octave change high run", n + 3, 8);
        run_len(1'b0, 16'd8, 3'd2, n);
        check_int("octave change first low run", n + 1, 2);
        run_len(1'b1, 16'd8, 3'd2, n);
        check_int("octave change next high run", n + 1, 2);

        // Key release 3 cycles into high, then restart with a full high phase.
        step(1'b1, 1'b1, 16'd10, 3'd0);
        step(1'b0, 1'b1, 16'd10, 3'd0);
        step(1'b0, 1'b1, 16'd10, 3'd0);
        step(1'b0, 1'b1, 16'd10, 3'd0);
        step(1'b0, 1'b0, 16'd10, 3'd0);
        check_int("release tone", int'(tone_out), 0);
        check_int("release active", int'(active), 0);
        step(1'b0, 1'b1, 16'd10, 3'd0);
        check_int("restart rise_tick", int'(rise_tick), 1);
        run_len(1'b1, 16'd10, 3'd0, n);
        check_int("restart high run", n + 1, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
